// File: rtl/fc_requant_buffer.sv
// fc_requant_buffer: captures one FC layer's ReLU'd accumulators,
// requantizes them serially and hands the vector to the next layer.
module fc_requant_buffer #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int N     = 128,
  parameter int SHIFT = 8,
  localparam int ACC_W = WIDTH * 2 + $clog2(IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc [0:N-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x [0:N-1],
  output logic             busy
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
  localparam logic [ACC_W:0] QMAX =
    (ACC_W+1)'((1 << (WIDTH - 1)) - 1);

  typedef enum logic [1:0] {
    IDLE,
    QUANT,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_reg [0:N-1];
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] q_val;

  // Round half up, shift, clamp to the positive signed range.
  // The extra sum bit keeps the rounding add from wrapping.
  function automatic logic [WIDTH-1:0] quant(
    input logic [ACC_W-1:0] a
  );
    logic [ACC_W:0] sum;
    logic [ACC_W:0] r;
    sum = {1'b0, a} + RND;
    r   = sum >> SHIFT;
    if (a[ACC_W-1])
      return '0;
    if (r > QMAX)
      return QMAX[WIDTH-1:0];
    return r[WIDTH-1:0];
  endfunction

  assign last  = (cnt == LAST);
  assign q_val = quant(acc_reg[cnt]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          accept   = 1'b1;
          state_nx = QUANT;
        end
      end
      QUANT: begin
        busy = 1'b1;
        if (last)
          state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Element counter; stops at N-1 and restarts per vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (accept)
      cnt <= '0;
    else if (busy)
      cnt <= last ? '0 : cnt + 1'b1;
  end

  // Capture the whole accumulator vector at the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        acc_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++)
        acc_reg[i] <= in_acc[i];
    end
  end

  // One requantized element written per QUANT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        out_x[i] <= '0;
    end else if (busy) begin
      out_x[cnt] <= q_val;
    end
  end

endmodule

// File: tb/tb_fc_requant_buffer.sv
// tb_fc_requant_buffer: directed scoreboard bench, a 4-element
// instance for the directed cases and a default-size instance.
module tb_fc_requant_buffer;

  localparam int W  = 8;
  localparam int AW = 23;

  typedef logic [3:0][W-1:0]   v4_t;
  typedef logic [127:0][W-1:0] v128_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst4, iv4, ir4, ov4, or4, busy4;
  logic [AW-1:0] acc4 [0:3];
  logic [W-1:0]  x4   [0:3];

  logic          rst8, iv8, ir8, ov8, or8, busy8;
  logic [AW-1:0] acc8 [0:127];
  logic [W-1:0]  x8   [0:127];

  fc_requant_buffer #(
    .WIDTH(8), .IN(128), .N(4), .SHIFT(8)
  ) dut4 (
    .clk(clk), .rst(rst4),
    .in_valid(iv4), .in_ready(ir4), .in_acc(acc4),
    .out_valid(ov4), .out_ready(or4), .out_x(x4),
    .busy(busy4)
  );

  fc_requant_buffer dut128 (
    .clk(clk), .rst(rst8),
    .in_valid(iv8), .in_ready(ir8), .in_acc(acc8),
    .out_valid(ov8), .out_ready(or8), .out_x(x8),
    .busy(busy8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  v4_t   q4 [$];
  v128_t q8 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Independent reference: SHIFT=8, WIDTH=8 requantizer.
  function automatic logic [W-1:0] qref(input logic [AW-1:0] a);
    int unsigned r;
    if (a[AW-1]) return '0;
    r = (int'(a) + 128) / 256;
    if (r > 127) return 8'd127;
    return W'(r);
  endfunction

  // Monitors: pop and compare at every output handshake.
  always @(negedge clk) begin : mon4
    v4_t e;
    if (!rst4 && ov4 && or4) begin
      if (q4.size() == 0) begin
        chk("unexpected_out4", 1, 0);
      end else begin
        e = q4.pop_front();
        for (int i = 0; i < 4; i++)
          chk($sformatf("out4[%0d]", i), x4[i], e[i]);
      end
    end
  end

  always @(negedge clk) begin : mon128
    v128_t e;
    if (!rst8 && ov8 && or8) begin
      if (q8.size() == 0) begin
        chk("unexpected_out128", 1, 0);
      end else begin
        e = q8.pop_front();
        for (int i = 0; i < 128; i++)
          chk($sformatf("out128[%0d]", i), x8[i], e[i]);
      end
    end
  end

  // Offer a vector; returns the cycle stamp of the accept edge.
  task automatic send4(input logic [3:0][AW-1:0] a,
                       input v4_t e,
                       output int t);
    bit ok = 0;
    iv4 = 1'b1;
    for (int i = 0; i < 4; i++) acc4[i] = a[i];
    t = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir4) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout4", 0, 1);
      iv4 = 1'b0;
      return;
    end
    q4.push_back(e);
    t = cyc;
    @(posedge clk); #1;
    iv4 = 1'b0;
    for (int i = 0; i < 4; i++) acc4[i] = AW'($urandom);
  endtask

  // Edges counted from the accept edge until out_valid shows.
  task automatic wait_ov4(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      n++;
      if (ov4) return;
    end
    chk("valid_timeout4", 0, 1);
  endtask

  task automatic run128(input int seed);
    v128_t e;
    int n;
    bit ok = 0;
    for (int i = 0; i < 128; i++)
      acc8[i] = AW'($urandom_range(0, 40000));
    acc8[0] = 23'h3FFFFF;
    acc8[1] = 23'h400000;
    acc8[2] = AW'(32639);
    acc8[3] = AW'(127 + seed);
    for (int i = 0; i < 128; i++) e[i] = qref(acc8[i]);
    iv8 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ir8) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout128", 0, 1);
      iv8 = 1'b0;
      return;
    end
    q8.push_back(e);
    @(posedge clk); #1;
    iv8 = 1'b0;
    for (int i = 0; i < 128; i++) acc8[i] = '0;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      n++;
      if (ov8) break;
    end
    chk("latency128", n, 128);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("done128_valid", ov8, 0);
  endtask

  initial begin
    int t1, t2, n;
    rst4 = 1'b1; rst8 = 1'b1;
    iv4 = 1'b0; iv8 = 1'b0;
    or4 = 1'b0; or8 = 1'b0;
    for (int i = 0; i < 4; i++) acc4[i] = '0;
    for (int i = 0; i < 128; i++) acc8[i] = '0;
    #1;
    chk("rst_in_ready", ir4, 0);
    chk("rst_out_valid", ov4, 0);
    chk("rst_x0", x4[0], 0);
    chk("rst_x3", x4[3], 0);
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0; rst8 = 1'b0;
    #1;
    chk("idle_in_ready", ir4, 1);
    chk("idle_busy", busy4, 0);

    // Round/shift; accept edge closes cycle 0, out_valid
    // appears in cycle N+1, i.e. after N more edges.
    send4({23'd0, 23'd127, 23'd384, 23'd255},
          {8'd0, 8'd0, 8'd2, 8'd1}, t1);
    chk("quant_busy", busy4, 1);
    chk("quant_in_ready", ir4, 0);
    wait_ov4(n);
    chk("latency4", n, 4);
    chk("hold_in_ready", ir4, 0);
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    chk("release_valid", ov4, 0);
    chk("release_ready", ir4, 1);

    // Saturation and the negative (sign bit) case.
    or4 = 1'b1;
    send4({23'h400000, 23'h3FFFFF, 23'd32640, 23'd32512},
          {8'd0, 8'd127, 8'd127, 8'd127}, t1);
    wait_ov4(n);
    @(posedge clk); #1;

    // Backpressure: output held stable for 20 cycles.
    or4 = 1'b0;
    send4({23'd100, 23'd20000, 23'd5000, 23'd1000},
          {8'd0, 8'd78, 8'd20, 8'd4}, t1);
    wait_ov4(n);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", ov4, 1);
      chk("bp_ready", ir4, 0);
      chk("bp_x", {x4[3], x4[2], x4[1], x4[0]},
          {8'd0, 8'd78, 8'd20, 8'd4});
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    chk("bp_release_valid", ov4, 0);
    chk("bp_release_ready", ir4, 1);

    // Back-to-back with in_valid held and out_ready tied high.
    or4 = 1'b1;
    send4({23'd384, 23'd383, 23'd127, 23'd128},
          {8'd2, 8'd1, 8'd0, 8'd1}, t1);
    send4({23'd65535, 23'd1, 23'd25472, 23'd25600},
          {8'd127, 8'd0, 8'd100, 8'd100}, t2);
    chk("b2b_spacing", t2 - t1, 6);
    wait_ov4(n);
    @(posedge clk); #1;

    // Reset while cnt==2 aborts the vector.
    or4 = 1'b0;
    send4({23'd512, 23'd512, 23'd512, 23'd512},
          {8'd2, 8'd2, 8'd2, 8'd2}, t1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b1;
    #1;
    void'(q4.pop_back());
    chk("abort_valid", ov4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_x", {x4[3], x4[2], x4[1], x4[0]}, 0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    #1;
    chk("abort_ready", ir4, 1);
    or4 = 1'b1;
    send4({23'd767, 23'd640, 23'd639, 23'd256},
          {8'd3, 8'd3, 8'd2, 8'd1}, t1);
    wait_ov4(n);
    chk("after_abort_latency", n, 4);
    @(posedge clk); #1;
    or4 = 1'b0;

    // Default-size instance against the reference model.
    run128(0);
    run128(1);

    repeat (4) @(posedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q128_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
